// File: rtl/conv2d_dw_pkg.sv
// conv2d_dw_pkg: shared types and constant helpers for the depthwise conv block.
// FSM encoding, dimension math and flat-bus element index helpers.
package conv2d_dw_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int n;
    r = 0;
    n = 1;
    while (n < v) begin
      n = n * 2;
      r++;
    end
    return r;
  endfunction

  // width of a counter able to index 0..n-1 (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int out_dim(input int in, input int k,
                                 input int pad, input int stride);
    return (in + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int img_idx(input int c, input int y, input int x,
                                 input int h, input int w);
    return (c * h + y) * w + x;
  endfunction

  function automatic int wt_idx(input int c, input int ky, input int kx,
                                input int kh, input int kw);
    return (c * kh + ky) * kw + kx;
  endfunction

  function automatic int res_idx(input int c, input int oy, input int ox,
                                 input int oh, input int ow);
    return (c * oh + oy) * ow + ox;
  endfunction

endpackage

// File: rtl/conv2d_dw_pe.sv
// conv2d_dw_pe: combinational MAC + bias + narrowing + activation for one pixel.
// pix_i/wgt_i: NTAP packed signed pairs; bias_i: channel bias; pix_o: OBW result.
// Narrowing saturates when CONV2D_DW_SATURATE_EN is defined, else wraps.
module conv2d_dw_pe
  import conv2d_dw_pkg::*;
#(
  parameter int BITWIDTH              = 8,
  parameter int OBW                   = 16,
  parameter int NTAP                  = 9,
  parameter int USING_BIAS            = 0,
  parameter int USING_ACTIVATION      = 1,
  parameter int ACTIVATION_IS_RELU    = 1,
  parameter int ACTIVATION_THRESSHOLD = 0,
  parameter int ACTIVATION_MAX_VAL    = 6
) (
  input  logic [NTAP*BITWIDTH-1:0] pix_i,
  input  logic [NTAP*BITWIDTH-1:0] wgt_i,
  input  logic [BITWIDTH-1:0]      bias_i,
  output logic [OBW-1:0]           pix_o
);

  localparam int PW = 2 * BITWIDTH;
  // one spare bit so the bias add can never wrap
  localparam int AW = PW + clog2(NTAP) + 1;

  localparam logic signed [BITWIDTH-1:0] THR_B =
    BITWIDTH'(ACTIVATION_THRESSHOLD);
  localparam logic signed [OBW-1:0] THR  = OBW'(THR_B);
  localparam logic signed [OBW-1:0] MAXV = OBW'(ACTIVATION_MAX_VAL);

  logic signed [PW-1:0]  prod [NTAP];
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_b;
  logic signed [OBW-1:0] nv;

  for (genvar i = 0; i < NTAP; i++) begin : g_mul
    assign prod[i] = $signed(pix_i[i*BITWIDTH +: BITWIDTH])
                   * $signed(wgt_i[i*BITWIDTH +: BITWIDTH]);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++) begin
      acc = acc + AW'(prod[i]);
    end
    acc_b = acc + ((USING_BIAS != 0) ? AW'($signed(bias_i)) : '0);
  end

`ifdef CONV2D_DW_SATURATE_EN
  localparam logic signed [AW-1:0] SMAX =
    {{(AW-OBW+1){1'b0}}, {(OBW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-OBW+1){1'b1}}, {(OBW-1){1'b0}}};

  always_comb begin
    nv = OBW'(acc_b);
    if (acc_b > SMAX) nv = OBW'(SMAX);
    else if (acc_b < SMIN) nv = OBW'(SMIN);
  end
`else
  assign nv = OBW'(acc_b);
`endif

  always_comb begin
    pix_o = nv;
    if (USING_ACTIVATION != 0) begin
      if (ACTIVATION_IS_RELU != 0) begin
        pix_o = (nv > THR) ? nv : '0;
      end else begin
        if (nv < 0) pix_o = '0;
        else if (nv > MAXV) pix_o = MAXV;
      end
    end
  end

endmodule

// File: rtl/conv2d_depthwise.sv
// conv2d_depthwise: depthwise 2-D conv layer, one output pixel per clock.
// valid/image/weights_mem/bias_mem in; ready/result (full feature map) out.
// Optional saturating narrowing via macro CONV2D_DW_SATURATE_EN.
module conv2d_depthwise
  import conv2d_dw_pkg::*;
#(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
  parameter int IMAGE_WIDTH              = 28,
  parameter int IMAGE_HEIGHT             = 28,
  parameter int WEIGHT_WIDTH             = 3,
  parameter int WEIGHT_HEIGHT            = 3,
  parameter int INOUT_CHANNEL            = 1,
  parameter int STRIDE                   = 1,
  parameter int PADDING                  = 0,
  parameter int USING_BIAS               = 0,
  parameter int USING_ACTIVATION         = 1,
  parameter int ACTIVATION_IS_RELU       = 1,
  parameter int ACTIVATION_THRESSHOLD    = 0,
  parameter int ACTIVATION_MAX_VAL       = 6,
  localparam int BW  = BITWIDTH,
  localparam int OBW = (IS_BITWIDTH_DOUBLE_SCALE != 0) ? 2*BW : BW,
  localparam int W   = IMAGE_WIDTH,
  localparam int H   = IMAGE_HEIGHT,
  localparam int KW  = WEIGHT_WIDTH,
  localparam int KH  = WEIGHT_HEIGHT,
  localparam int C   = INOUT_CHANNEL,
  localparam int OW  = out_dim(W, KW, PADDING, STRIDE),
  localparam int OH  = out_dim(H, KH, PADDING, STRIDE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic [C*H*W*BW-1:0]     image,
  input  logic [C*KH*KW*BW-1:0]   weights_mem,
  input  logic [C*BW-1:0]         bias_mem,
  output logic                    ready,
  output logic [C*OH*OW*OBW-1:0]  result
);

  localparam int NTAP = KH * KW;
  localparam int XW   = idx_w(OW);
  localparam int YW   = idx_w(OH);
  localparam int CW   = idx_w(C);

  state_e state_q, state_d;

  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [CW-1:0] c_q,  c_d;
  logic          ready_q, ready_d;
  logic          arm_q;
  logic          load;
  logic          wr;
  logic          accept;

  logic [C*H*W*BW-1:0]    img_q;
  logic [C*KH*KW*BW-1:0]  wgt_q;
  logic [C*BW-1:0]        bias_q;
  logic [C*OH*OW*OBW-1:0] res_q;

  logic [NTAP*BW-1:0] win_pix;
  logic [NTAP*BW-1:0] win_wgt;
  logic [BW-1:0]      bias_sel;
  logic [OBW-1:0]     pe_pix;
  int                 iy;
  int                 ix;

  // arm_q blocks a valid coinciding with the first edge after reset release
  assign accept = valid && arm_q && (state_q != S_COMPUTE);

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    c_d     = c_q;
    ready_d = ready_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          load    = 1'b1;
          ready_d = 1'b0;
          ox_d    = '0;
          oy_d    = '0;
          c_d     = '0;
          state_d = S_COMPUTE;
        end else if (state_q == S_DONE) begin
          ready_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        wr = 1'b1;
        if (ox_q == XW'(OW-1)) begin
          ox_d = '0;
          if (oy_q == YW'(OH-1)) begin
            oy_d = '0;
            if (c_q == CW'(C-1)) begin
              c_d     = '0;
              state_d = S_DONE;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            oy_d = oy_q + YW'(1);
          end
        end else begin
          ox_d = ox_q + XW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      arm_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q  <= '0;
      wgt_q  <= '0;
      bias_q <= '0;
    end else if (load) begin
      img_q  <= image;
      wgt_q  <= weights_mem;
      bias_q <= bias_mem;
    end
  end

  // window gather; taps outside the image read as zero
  always_comb begin
    win_pix = '0;
    win_wgt = '0;
    iy      = 0;
    ix      = 0;
    for (int ky = 0; ky < KH; ky++) begin
      for (int kx = 0; kx < KW; kx++) begin
        iy = int'(oy_q) * STRIDE + ky - PADDING;
        ix = int'(ox_q) * STRIDE + kx - PADDING;
        win_wgt[(ky*KW+kx)*BW +: BW] =
          wgt_q[wt_idx(int'(c_q), ky, kx, KH, KW)*BW +: BW];
        if (iy >= 0 && iy < H && ix >= 0 && ix < W) begin
          win_pix[(ky*KW+kx)*BW +: BW] =
            img_q[img_idx(int'(c_q), iy, ix, H, W)*BW +: BW];
        end
      end
    end
  end

  assign bias_sel = bias_q[int'(c_q)*BW +: BW];

  conv2d_dw_pe #(
    .BITWIDTH              (BW),
    .OBW                   (OBW),
    .NTAP                  (NTAP),
    .USING_BIAS            (USING_BIAS),
    .USING_ACTIVATION      (USING_ACTIVATION),
    .ACTIVATION_IS_RELU    (ACTIVATION_IS_RELU),
    .ACTIVATION_THRESSHOLD (ACTIVATION_THRESSHOLD),
    .ACTIVATION_MAX_VAL    (ACTIVATION_MAX_VAL)
  ) u_pe (
    .pix_i  (win_pix),
    .wgt_i  (win_wgt),
    .bias_i (bias_sel),
    .pix_o  (pe_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (wr) begin
      res_q[res_idx(int'(c_q), int'(oy_q), int'(ox_q), OH, OW)*OBW +: OBW]
        <= pe_pix;
    end
  end

  assign ready  = ready_q;
  assign result = res_q;

endmodule

// File: tb/tb_conv2d_depthwise.sv
// tb_conv2d_depthwise: directed scoreboard bench for conv2d_depthwise.
// Three instances: defaults, bias/no-activation, and padding=1/stride=2.
module tb_conv2d_depthwise;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int N0 = 26 * 26;
  localparam int N2 = 14 * 14;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic [H*W*8-1:0] image;
  logic [9*8-1:0]   wts;
  logic [7:0]       bias;
  logic rdy0, rdy1, rdy2;
  logic [N0*16-1:0] res0;
  logic [N0*16-1:0] res1;
  logic [N2*16-1:0] res2;

  int total = 0;
  int bad   = 0;

  int img [H][W];
  int wt  [3][3];
  int bias_v;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  always #5 clk = ~clk;

  conv2d_depthwise u_d0 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .image(image),
    .weights_mem(wts), .bias_mem(bias), .ready(rdy0), .result(res0)
  );

  conv2d_depthwise #(
    .USING_BIAS(1), .USING_ACTIVATION(0)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .image(image),
    .weights_mem(wts), .bias_mem(bias), .ready(rdy1), .result(res1)
  );

  conv2d_depthwise #(
    .PADDING(1), .STRIDE(2)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .image(image),
    .weights_mem(wts), .bias_mem(bias), .ready(rdy2), .result(res2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int oy, input int ox,
                                        input int pad, input int st,
                                        input int use_b, input int use_a);
    int acc;
    int iy;
    int ix;
    int v;
    logic [15:0] n;
    acc = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        iy = oy * st + ky - pad;
        ix = ox * st + kx - pad;
        if (iy >= 0 && iy < H && ix >= 0 && ix < W)
          acc += img[iy][ix] * wt[ky][kx];
      end
    if (use_b != 0) acc += bias_v;
`ifdef CONV2D_DW_SATURATE_EN
    v = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
`else
    v = acc;
`endif
    n = 16'(v);
    if (use_a != 0 && !($signed(n) > 0)) n = 16'h0000;
    return n;
  endfunction

  task automatic fill(input int iv, input int wv);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = iv;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) wt[ky][kx] = wv;
  endtask

  task automatic pack();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) image[(y*W+x)*8 +: 8] = 8'(img[y][x]);
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) wts[(ky*3+kx)*8 +: 8] = 8'(wt[ky][kx]);
    bias = 8'(bias_v);
  endtask

  // drive a job and record what each instance must produce
  task automatic start(input string tag);
    pack();
    for (int oy = 0; oy < 26; oy++)
      for (int ox = 0; ox < 26; ox++) begin
        q0.push_back(model(oy, ox, 0, 1, 0, 1));
        q1.push_back(model(oy, ox, 0, 1, 1, 0));
      end
    for (int oy = 0; oy < 14; oy++)
      for (int ox = 0; ox < 14; ox++)
        q2.push_back(model(oy, ox, 1, 2, 0, 1));
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk({tag, "_rdy_drop"}, {31'b0, rdy0}, 32'd0);
  endtask

  // wait for all instances, optionally pulsing valid mid-run, then drain
  task automatic finish_run(input string tag, input int mid);
    int l0, l1, l2;
    logic [15:0] e;
    l0 = -1;
    l1 = -1;
    l2 = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      valid = (k == mid);
      if (k == mid) begin
        fill(2, 3);
        pack();
      end
      if (rdy0 && l0 < 0) l0 = k;
      if (rdy1 && l1 < 0) l1 = k;
      if (rdy2 && l2 < 0) l2 = k;
      if (l0 > 0 && l1 > 0 && l2 > 0) break;
    end
    valid = 1'b0;
    chk({tag, "_lat0"}, l0, 677);
    chk({tag, "_lat1"}, l1, 677);
    chk({tag, "_lat2"}, l2, 197);
    for (int i = 0; i < N0; i++) begin
      e = q0.pop_front();
      chk($sformatf("%s_d0_px%0d", tag, i), {16'b0, res0[i*16 +: 16]}, {16'b0, e});
      e = q1.pop_front();
      chk($sformatf("%s_d1_px%0d", tag, i), {16'b0, res1[i*16 +: 16]}, {16'b0, e});
    end
    for (int i = 0; i < N2; i++) begin
      e = q2.pop_front();
      chk($sformatf("%s_d2_px%0d", tag, i), {16'b0, res2[i*16 +: 16]}, {16'b0, e});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, {29'b0, rdy0, rdy1, rdy2}, 32'd0);
    chk({tag, "_res"}, {29'b0, |res0, |res1, |res2}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    bias_v = 0;
    fill(0, 0);
    pack();

    // reset with valid toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      valid = ~valid;
    end
    chk_zero("reset");
    // release reset with valid high on the same edge: must be ignored
    fill(1, 1);
    pack();
    valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk_zero("post_rst");

    // all ones
    fill(1, 1);
    bias_v = 0;
    start("ones");
    finish_run("ones", 0);
    chk("ones_d0_px0", {16'b0, res0[15:0]}, 32'd9);
    chk("ones_d2_corner", {16'b0, res2[0 +: 16]}, 32'd4);
    chk("ones_d2_top", {16'b0, res2[5*16 +: 16]}, 32'd6);
    chk("ones_d2_left", {16'b0, res2[(5*14)*16 +: 16]}, 32'd6);
    chk("ones_d2_mid", {16'b0, res2[(5*14+5)*16 +: 16]}, 32'd9);
    chk("ones_d2_br", {16'b0, res2[(13*14+13)*16 +: 16]}, 32'd9);
    repeat (20) @(posedge clk);
    #1;
    chk("ones_rdy_hold", {31'b0, rdy0}, 32'd1);

    // centre tap only, diagonal ramp image, bias 3
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x + y) & 63;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) wt[ky][kx] = (ky == 1 && kx == 1) ? 1 : 0;
    bias_v = 3;
    start("ramp");
    finish_run("ramp", 0);
    chk("ramp_d0_first", {16'b0, res0[15:0]}, 32'd2);
    chk("ramp_d0_last", {16'b0, res0[(N0-1)*16 +: 16]}, 32'd52);
    chk("ramp_d1_first", {16'b0, res1[15:0]}, 32'd5);

    // negative weights
    fill(1, -1);
    bias_v = 0;
    start("neg");
    finish_run("neg", 0);
    chk("neg_d0_relu", {16'b0, res0[15:0]}, 32'd0);
    chk("neg_d1_raw", {16'b0, res1[15:0]}, 32'h0000fff7);

    // large values exercise narrowing
    fill(127, 127);
    start("big");
    finish_run("big", 0);
`ifdef CONV2D_DW_SATURATE_EN
    chk("big_d0", {16'b0, res0[15:0]}, 32'd32767);
`else
    chk("big_d0", {16'b0, res0[15:0]}, 32'd14089);
`endif

    // valid during compute is ignored
    fill(1, 1);
    start("midv");
    finish_run("midv", 100);
    chk("midv_d0_px0", {16'b0, res0[15:0]}, 32'd9);

    // reset during compute aborts and clears
    fill(1, 1);
    pack();
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("abort_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
